// File: rtl/dma_lite_pkg.sv
// Shared constants for the DMA-lite config sequencer: register offsets, default
// control word and FSM state encoding.
package dma_lite_pkg;

  localparam logic [9:0] OFF_MM2S_DMACR = 10'h000;
  localparam logic [9:0] OFF_MM2S_SA    = 10'h018;
  localparam logic [9:0] OFF_MM2S_LEN   = 10'h028;
  localparam logic [9:0] OFF_S2MM_DMACR = 10'h030;
  localparam logic [9:0] OFF_S2MM_DA    = 10'h048;
  localparam logic [9:0] OFF_S2MM_LEN   = 10'h058;

  // RS=1, IOC_IrqEn=1
  localparam logic [31:0] DMACR_DEFAULT = 32'h0000_1001;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_END = 3'd2;
  localparam logic [2:0] ST_FINISH   = 3'd3;
  localparam logic [2:0] ST_WD_ERR   = 3'd4;

  // Register offset for a given channel direction and write step (0..2).
  function automatic logic [9:0] reg_offset(input logic dir, input logic [1:0] step);
    logic [9:0] off;
    case ({dir, step})
      3'b0_00: off = OFF_MM2S_DMACR;
      3'b0_01: off = OFF_MM2S_SA;
      3'b0_10: off = OFF_MM2S_LEN;
      3'b1_00: off = OFF_S2MM_DMACR;
      3'b1_01: off = OFF_S2MM_DA;
      3'b1_10: off = OFF_S2MM_LEN;
      default: off = 10'h000;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/dma_lite_wd_timer.sv
// Watchdog for one outstanding register write: counts enabled cycles since the
// last clear and flags the cycle in which the budget is used up.
module dma_lite_wd_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // cnt holds the number of enabled cycles already elapsed, so the last allowed
  // cycle is the one where cnt == TIMEOUT_CYC-1.
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (TIMEOUT_CYC != 0) && en && (cnt == LAST);

endmodule

// File: rtl/dma_lite_cfg_seq.sv
// Sequencer that turns one DMA transfer command into the three AXI-Lite register
// writes (DMACR, SA/DA, LENGTH) issued through the lite write controller.
//
// Handshakes: a command transfers on the rising edge where cmd_valid & cmd_ready;
// cmd_ready is high only in IDLE. Towards the controller, lite_valid is a one-cycle
// start pulse and lite_end a one-cycle completion pulse; a new lite_valid is only
// raised the cycle after the previous lite_end, and awaddr/wdata stay stable between.
module dma_lite_cfg_seq
  import dma_lite_pkg::*;
#(
  parameter logic [31:0] DMACR_VAL   = DMACR_DEFAULT,
  parameter int unsigned LEN_W       = 26,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             lite_valid,
  output logic [9:0]       lite_awaddr,
  output logic [31:0]      lite_wdata,
  input  logic             lite_end,
  output logic             busy,
  output logic             done,
  output logic             done_err,
  output logic             wd_err,
  output logic [2:0]       dbg_state
);

  logic [2:0]       state;
  logic [1:0]       step;
  logic             dir_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic [31:0]      len_ext;
  logic             wd_expire;

  always_comb begin
    len_ext = '0;
    len_ext[LEN_W-1:0] = len_q;
  end

  dma_lite_wd_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_ISSUE),
    .en    (state == ST_WAIT_END),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      step        <= 2'd0;
      dir_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      lite_awaddr <= '0;
      lite_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            dir_q  <= cmd_dir;
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            step   <= 2'd0;
            if (cmd_len != '0) begin
              state       <= ST_ISSUE;
              err_q       <= 1'b0;
              lite_awaddr <= reg_offset(cmd_dir, 2'd0);
              lite_wdata  <= DMACR_VAL;
            end else begin
              state <= ST_FINISH;
              err_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT_END;
        ST_WAIT_END: begin
          // A completion in the expiry cycle still counts as success.
          if (lite_end) begin
            if (step != 2'd2) begin
              step        <= step + 2'd1;
              state       <= ST_ISSUE;
              lite_awaddr <= reg_offset(dir_q, step + 2'd1);
              lite_wdata  <= (step == 2'd0) ? addr_q : len_ext;
            end else begin
              state <= ST_FINISH;
            end
          end else if (wd_expire) begin
            state <= ST_WD_ERR;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        ST_WD_ERR: state <= ST_WD_ERR;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign lite_valid = (state == ST_ISSUE);
  assign done       = (state == ST_FINISH);
  assign done_err   = (state == ST_FINISH) && err_q;
  assign wd_err     = (state == ST_WD_ERR);
  assign dbg_state  = state;

endmodule

// File: tb/tb_dma_lite_cfg_seq.sv
// Randomized self-checking bench for dma_lite_cfg_seq: a responder stands in for
// the lite write controller, a scoreboard checks every write, done and latency.
module tb_dma_lite_cfg_seq;

  localparam int          LEN_W = 26;
  localparam logic [31:0] DMACR = 32'h0000_1001;

  logic             clk;
  logic             rst;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_dir = 1'b0;
  logic [31:0]      cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             lite_valid;
  logic [9:0]       lite_awaddr;
  logic [31:0]      lite_wdata;
  logic             lite_end = 1'b0;
  logic             busy;
  logic             done;
  logic             done_err;
  logic             wd_err;
  logic [2:0]       dbg_state;

  dma_lite_cfg_seq #(
    .DMACR_VAL  (DMACR),
    .LEN_W      (LEN_W),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .lite_valid (lite_valid),
    .lite_awaddr(lite_awaddr),
    .lite_wdata (lite_wdata),
    .lite_end   (lite_end),
    .busy       (busy),
    .done       (done),
    .done_err   (done_err),
    .wd_err     (wd_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [41:0] exp_q[$];   // {awaddr, wdata} per expected write
  logic        done_q[$];  // expected done_err per command

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_lite_valid", 64'(lite_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_done_err", 64'(done_err), 64'd0);
    check("rst_wd_err", 64'(wd_err), 64'd0);
    check("rst_awaddr", 64'(lite_awaddr), 64'd0);
    check("rst_wdata", 64'(lite_wdata), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic void model_push(input logic d, input logic [31:0] a, input logic [LEN_W-1:0] l);
    logic [9:0] base;
    if (l == '0) begin
      done_q.push_back(1'b1);
    end else begin
      base = d ? 10'h030 : 10'h000;
      exp_q.push_back({base, DMACR});
      exp_q.push_back({base + 10'h018, a});
      exp_q.push_back({base + 10'h028, 32'(l)});
      done_q.push_back(1'b0);
    end
  endfunction

  // ---------------- controller responder ----------------
  int unsigned end_delay   = 5;
  bit          rand_delay  = 1'b0;
  bit          spurious_en = 1'b0;
  int          withhold_at = 0;
  int          nvalid      = 0;
  bit          pend        = 1'b0;
  int          cd          = 0;

  always begin
    @(negedge clk);
    lite_end = 1'b0;
    if (rst) begin
      pend   = 1'b0;
      nvalid = 0;
    end else if (lite_valid) begin
      nvalid++;
      pend = !(withhold_at != 0 && nvalid == withhold_at);
      cd   = rand_delay ? int'($urandom_range(1, 10)) : int'(end_delay);
      if (spurious_en) lite_end = 1'b1;
    end else if (pend) begin
      cd--;
      if (cd == 0) begin
        lite_end = 1'b1;
        pend     = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          exp_next = 1'b0;
  bit          exp_kind = 1'b0;   // 1: next response is a write, 0: done
  bit          outstanding = 1'b0;
  logic [41:0] held = '0;

  always begin
    bit          nxt;
    bit          kind;
    logic [41:0] e;
    @(negedge clk);
    #1;
    if (rst) begin
      exp_next    = 1'b0;
      outstanding = 1'b0;
    end else begin
      check("valid_timing", 64'(lite_valid), 64'(exp_next && exp_kind));
      check("done_timing", 64'(done), 64'(exp_next && !exp_kind));
      if (lite_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("write", {22'd0, lite_awaddr, lite_wdata}, {22'd0, e});
        end else begin
          check("write_unexpected", 64'd1, 64'd0);
        end
        held = {lite_awaddr, lite_wdata};
      end
      if (done) begin
        if (done_q.size() > 0) check("done_err", 64'(done_err), 64'(done_q.pop_front()));
        else check("done_unexpected", 64'd1, 64'd0);
      end
      if (outstanding) check("hold", {22'd0, lite_awaddr, lite_wdata}, {22'd0, held});
      nxt  = 1'b0;
      kind = 1'b0;
      if (cmd_valid && cmd_ready) begin
        nxt  = 1'b1;
        kind = (exp_q.size() > 0);
      end
      if (outstanding && lite_end) begin
        nxt         = 1'b1;
        kind        = (exp_q.size() > 0);
        outstanding = 1'b0;
      end
      if (lite_valid) outstanding = 1'b1;
      exp_next = nxt;
      exp_kind = kind;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic d, input logic [31:0] a, input logic [LEN_W-1:0] l);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_addr  = a;
    cmd_len   = l;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n < 3000), 64'd1);
    if (n < 3000) model_push(d, a, l);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit junk);
    int n = 0;
    while (n < 3000) begin
      if (junk) begin
        if (cmd_ready) begin
          cmd_valid = 1'b0;
        end else begin
          cmd_valid = 1'b1;
          cmd_dir   = 1'($urandom);
          cmd_addr  = $urandom;
          cmd_len   = LEN_W'($urandom);
        end
      end
      #2;
      if (cmd_ready && exp_q.size() == 0 && done_q.size() == 0) break;
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    check("idle_timeout", 64'(n < 3000), 64'd1);
  endtask

  task automatic wait_valids(input int n);
    int seen = 0;
    int c = 0;
    while (c < 500) begin
      #2;
      if (lite_valid) seen++;
      if (seen >= n) break;
      @(negedge clk);
      c++;
    end
    check("wait_valid_timeout", 64'(seen), 64'(n));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    apply_reset();

    // Directed MM2S, fixed 5-cycle completion
    end_delay = 5;
    send(1'b0, 32'h1000_0000, 26'd4096);
    wait_idle(1'b0);

    // Directed S2MM, maximum length
    send(1'b1, 32'hA000_0040, 26'h3FF_FFFF);
    wait_idle(1'b0);

    // Zero length: rejected without writes
    send(1'b0, 32'h1234_5678, 26'd0);
    wait_idle(1'b0);
    check("zero_len_ready", 64'(cmd_ready), 64'd1);

    // Commands while busy and lite_end during ISSUE are both ignored
    spurious_en = 1'b1;
    send(1'b1, 32'h0BAD_F00D, 26'd77);
    wait_idle(1'b1);
    spurious_en = 1'b0;

    // Randomized commands and completion delays
    rand_delay = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int unsigned r;
      logic [LEN_W-1:0] l;
      r = $urandom_range(0, 9);
      if (r == 0) l = '0;
      else if (r == 1) l = 26'h3FF_FFFF;
      else l = LEN_W'($urandom_range(1, 32'h00FF_FFFF));
      send(1'($urandom), $urandom, l);
      wait_idle(i[0]);
    end
    rand_delay = 1'b0;

    // Reset during WAIT_END of step 1, then a fresh command from step 0
    end_delay = 8;
    send(1'b0, 32'h5555_AAAA, 26'd300);
    wait_valids(2);
    repeat (3) @(negedge clk);
    apply_reset();
    end_delay = 5;
    send(1'b1, 32'h7777_0000, 26'd12);
    wait_idle(1'b0);

    // Watchdog: withhold completion of the second write
    apply_reset();
    withhold_at = 2;
    send(1'b0, 32'hC0DE_0000, 26'd64);
    wait_valids(2);
    c = 0;
    while (!wd_err && c < 100) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("wd_latency", 64'(c), 64'd17);
    @(negedge clk);
    cmd_valid = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    check("wd_sticky", 64'(wd_err), 64'd1);
    check("wd_cmd_ready", 64'(cmd_ready), 64'd0);
    check("wd_busy", 64'(busy), 64'd1);
    cmd_valid = 1'b0;
    withhold_at = 0;
    apply_reset();
    send(1'b0, 32'h0000_0100, 26'd1);
    wait_idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete by %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
